sync_fifo_prog: RTL and testbench
=================================

// Module: sync_fifo_prog
// PURPOSE
//  Parametrised single-clock FIFO. Adds to the baseline FIFO:
//    - any depth >= 2, not only powers of two;
//    - runtime-programmable almost-full / almost-empty thresholds;
//    - a synchronous flush;
//    - an occupancy output;
//    - an optional first-word-fall-through (FWFT) read mode;
//    - a write accepted while full when a read happens in the same cycle.
//  It sits between a producer and a consumer in the verification-target datapath.
// PARAMETERS
//  FIFO_WIDTH  16  data word width, >= 1
//  FIFO_DEPTH  8   number of entries, >= 2 (any integer)
//  FWFT        0   0 = registered read (1-cycle latency); 1 = first-word-fall-through
//  AW          derived = $clog2(FIFO_DEPTH+1), width of level/threshold (localparam)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous active-low reset
//  flush        in   1           sync clear of contents, priority over rd_en/wr_en
//  wr_en        in   1           write request
//  data_in      in   FIFO_WIDTH  write data
//  rd_en        in   1           read request (FWFT=1: pop current head)
//  af_thresh    in   AW          almostfull threshold, quasi-static
//  ae_thresh    in   AW          almostempty threshold, quasi-static
//  data_out     out  FIFO_WIDTH  read data
//  rd_valid     out  1           FWFT=0: pulse, data_out updated this cycle; FWFT=1: = !empty
//  wr_ack       out  1           registered: previous-cycle write accepted
//  overflow     out  1           registered: previous-cycle write rejected
//  underflow    out  1           registered: previous-cycle read rejected
//  full, empty, almostfull, almostempty  out  1  status flags (comb. from level)
//  level        out  AW          current occupancy 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - Clears wr_ptr, rd_ptr, level, data_out, rd_valid, wr_ack, overflow and underflow to 0.
//   - All four flags are forced to 0 while rst_n=0.
//   - empty=1 from the first cycle after release.
//  Pointers wrap from FIFO_DEPTH-1 to 0 (explicit compare, not natural overflow).
//  Accept rules, evaluated on the pre-edge state:
//   - rd_ok = rd_en & (level!=0)
//   - wr_ok = wr_en & ((level<FIFO_DEPTH) | rd_ok)
//  Full + rd_en + wr_en:
//   - Both operations are accepted; level is unchanged.
//   - The write lands in the slot freed by the read.
//  Empty + rd_en + wr_en: write accepted, read rejected (underflow=1), level -> 1.
//  Level update: level <= level + wr_ok - rd_ok.
//  Registered status, each updated every edge from the same cycle's accept rules:
//   - wr_ack <= wr_ok
//   - overflow <= wr_en & !wr_ok
//   - underflow <= rd_en & !rd_ok
//  Flags:
//   - full = (level==FIFO_DEPTH)
//   - empty = (level==0)
//   - almostfull = (level>=af_thresh)
//   - almostempty = (level<=ae_thresh)
//   - The flags are non-exclusive (e.g. empty and almostempty both 1).
//  FWFT=0 read:
//   - On rd_ok, data_out <= mem[rd_ptr] and rd_valid <= 1, else rd_valid <= 0.
//   - data_out holds its value otherwise.
//  FWFT=1 read:
//   - data_out = mem[rd_ptr] combinationally whenever !empty, else holds the last value.
//   - rd_valid = !empty.
//   - rd_en pops the head at the edge.
//  flush=1 at an edge:
//   - Pointers and level go to 0; wr_ack, overflow and underflow go to 0.
//   - rd_en and wr_en are ignored that cycle.
//   - data_out is retained; FWFT=0 rd_valid goes to 0.
//  Reset asserted mid-burst aborts immediately; no partial state survives.
//  Out-of-range thresholds (> FIFO_DEPTH) are legal: flag stays 0 (af) or 1 (ae).
// TESTING
//  1. W=16,D=8,FWFT=0: reset, write 0x0001..0x0008
//     -> wr_ack x8, full=1, level=8; 9th write -> overflow=1, level=8.
//  2. Full FIFO, rd_en=wr_en=1 with data_in=0xBEEF, 8 cycles
//     -> full stays 1, wr_ack=1, data_out = 0x0001..0x0008 in order, each 1 cycle after its read.
//  3. Empty FIFO, rd_en=1 -> underflow=1 next cycle, level=0, data_out unchanged;
//     rd_en=wr_en=1 -> underflow=1, level=1.
//  4. D=6 (non-pow2): write 6, read 6, repeated 3 times
//     -> pointer wraps at 5->0, data order intact, empty=1 at end.
//  5. af_thresh=6, ae_thresh=2: fill 0->8
//     -> almostempty high for level 0..2; almostfull high for level 6..8.
//  6. FWFT=1: write 0x00AA
//     -> data_out=0x00AA, rd_valid=1 the cycle after the write with no rd_en;
//     flush with level=5 -> level=0, empty=1 next cycle;
//     rst_n low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/sync_fifo_prog_if.sv
// Handshake/data bundle between a producer/consumer pair and sync_fifo_prog.
// The FIFO takes the slave side; the bench or surrounding logic takes master.
interface sync_fifo_prog_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [AW-1:0]    af_thresh;
  logic [AW-1:0]    ae_thresh;
  logic [WIDTH-1:0] data_out;
  logic             rd_valid;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic             almostfull;
  logic             almostempty;
  logic [AW-1:0]    level;

  modport master (
    output flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    input  data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, level
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en, af_thresh, ae_thresh,
    output data_out, rd_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, level
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of any depth >= 2 with programmable almost-full/empty
// thresholds, synchronous flush, occupancy output and optional FWFT read.
// A write into a full FIFO is accepted when a read pops in the same cycle.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_L  = AW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         level_q, level_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_ok, wr_ok, not_empty;
  logic [FIFO_WIDTH-1:0] head;

  assign not_empty = (level_q != '0);
  assign head      = mem[rd_ptr_q];

  // Accept rules on the pre-edge state; a read frees a slot for a same-cycle write.
  assign rd_ok = bus.rd_en & not_empty;
  assign wr_ok = bus.wr_en & ((level_q != DEPTH_L) | rd_ok);

  // Next-state: flush wins over both requests, otherwise normal push/pop.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    dout_d      = dout_q;
    rd_valid_d  = 1'b0;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (FWFT != 0) begin
      // Keep a copy of the head so data_out can hold it once the FIFO drains.
      if (not_empty) dout_d = head;
    end
    if (!bus.flush) begin
      if (wr_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (rd_ok) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
      level_d     = level_q + AW'(wr_ok) - AW'(rd_ok);
      wr_ack_d    = wr_ok;
      overflow_d  = bus.wr_en & ~wr_ok;
      underflow_d = bus.rd_en & ~rd_ok;
      if (FWFT == 0) begin
        rd_valid_d = rd_ok;
        if (rd_ok) dout_d = head;
      end
    end else begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Control and output registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      dout_q      <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      dout_q      <= dout_d;
      rd_valid_q  <= rd_valid_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.flush) mem[wr_ptr_q] <= bus.data_in;
  end

  // FWFT shows the live head; registered mode shows the last popped word.
  assign bus.data_out  = (FWFT != 0 && not_empty) ? head : dout_q;
  assign bus.rd_valid  = (FWFT != 0) ? not_empty : rd_valid_q;
  assign bus.wr_ack    = wr_ack_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.level     = level_q;

  // Flags are held low while reset is asserted.
  assign bus.full        = rst_n & (level_q == DEPTH_L);
  assign bus.empty       = rst_n & ~not_empty;
  assign bus.almostfull  = rst_n & (level_q >= bus.af_thresh);
  assign bus.almostempty = rst_n & (level_q <= bus.ae_thresh);
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: D=8 registered, D=6 registered, D=8 FWFT.
module tb_sync_fifo_prog;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_prog_if #(.WIDTH(16), .DEPTH(8)) ia ();
  sync_fifo_prog_if #(.WIDTH(16), .DEPTH(6)) ib ();
  sync_fifo_prog_if #(.WIDTH(16), .DEPTH(8)) ic ();

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .FWFT(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

  // Advance one edge and settle; inputs change here, outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ia.flush = 0; ia.wr_en = 0; ia.rd_en = 0; ia.data_in = '0; ia.af_thresh = 4'd6; ia.ae_thresh = 4'd2;
    ib.flush = 0; ib.wr_en = 0; ib.rd_en = 0; ib.data_in = '0; ib.af_thresh = 3'd5; ib.ae_thresh = 3'd1;
    ic.flush = 0; ic.wr_en = 0; ic.rd_en = 0; ic.data_in = '0; ic.af_thresh = 4'd6; ic.ae_thresh = 4'd2;
    rst_n = 0;
    step(); step();
    n_tests++; if (ia.empty !== 1'b0 || ia.almostempty !== 1'b0 || ia.full !== 1'b0 || ia.almostfull !== 1'b0) begin n_fail++; $display("FAIL rst_flags_a: got e=%b ae=%b f=%b af=%b expected all 0", ia.empty, ia.almostempty, ia.full, ia.almostfull); end
    n_tests++; if (ia.level !== 4'd0 || ia.data_out !== 16'h0 || ia.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_a: got lvl=%0d do=%h rv=%b expected 0", ia.level, ia.data_out, ia.rd_valid); end
    n_tests++; if (ic.almostempty !== 1'b0 || ic.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_c: got ae=%b rv=%b expected 0 0", ic.almostempty, ic.rd_valid); end
    rst_n = 1;
    step();
    n_tests++; if (ia.empty !== 1'b1 || ia.almostempty !== 1'b1 || ia.full !== 1'b0) begin n_fail++; $display("FAIL post_rst_a: got e=%b ae=%b f=%b expected 1 1 0", ia.empty, ia.almostempty, ia.full); end
    n_tests++; if (ib.empty !== 1'b1 || ic.empty !== 1'b1) begin n_fail++; $display("FAIL post_rst_bc: got b.e=%b c.e=%b expected 1 1", ib.empty, ic.empty); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      ia.wr_en = 1; ia.data_in = 16'(i);
      step();
      n_tests++; if (ia.wr_ack !== 1'b1 || ia.level !== 4'(i)) begin n_fail++; $display("FAIL fill_%0d: got ack=%b lvl=%0d expected 1 %0d", i, ia.wr_ack, ia.level, i); end
    end
    n_tests++; if (ia.full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", ia.full); end
    ia.data_in = 16'h0009;
    step();
    ia.wr_en = 0;
    n_tests++; if (ia.overflow !== 1'b1 || ia.wr_ack !== 1'b0 || ia.level !== 4'd8) begin n_fail++; $display("FAIL overflow: got ovf=%b ack=%b lvl=%0d expected 1 0 8", ia.overflow, ia.wr_ack, ia.level); end
    step();
    n_tests++; if (ia.overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clr: got %b expected 0", ia.overflow); end
  endtask

  task automatic test_full_rw();
    ia.rd_en = 1; ia.wr_en = 1; ia.data_in = 16'hBEEF;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_tests++; if (ia.data_out !== 16'(i) || ia.rd_valid !== 1'b1) begin n_fail++; $display("FAIL full_rw_data_%0d: got %h rv=%b expected %h 1", i, ia.data_out, ia.rd_valid, 16'(i)); end
      n_tests++; if (ia.full !== 1'b1 || ia.wr_ack !== 1'b1 || ia.overflow !== 1'b0) begin n_fail++; $display("FAIL full_rw_st_%0d: got f=%b ack=%b ovf=%b expected 1 1 0", i, ia.full, ia.wr_ack, ia.overflow); end
    end
    ia.wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++; if (ia.data_out !== 16'hBEEF || ia.level !== 4'(7 - i)) begin n_fail++; $display("FAIL drain_%0d: got %h lvl=%0d expected beef %0d", i, ia.data_out, ia.level, 7 - i); end
    end
    ia.rd_en = 0;
    n_tests++; if (ia.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", ia.empty); end
  endtask

  task automatic test_underflow();
    ia.rd_en = 1;
    step();
    n_tests++; if (ia.underflow !== 1'b1 || ia.level !== 4'd0 || ia.data_out !== 16'hBEEF || ia.rd_valid !== 1'b0) begin n_fail++; $display("FAIL underflow: got udf=%b lvl=%0d do=%h rv=%b expected 1 0 beef 0", ia.underflow, ia.level, ia.data_out, ia.rd_valid); end
    ia.wr_en = 1; ia.data_in = 16'h1234;
    step();
    ia.wr_en = 0;
    n_tests++; if (ia.underflow !== 1'b1 || ia.wr_ack !== 1'b1 || ia.level !== 4'd1) begin n_fail++; $display("FAIL empty_rw: got udf=%b ack=%b lvl=%0d expected 1 1 1", ia.underflow, ia.wr_ack, ia.level); end
    step();
    ia.rd_en = 0;
    n_tests++; if (ia.data_out !== 16'h1234 || ia.underflow !== 1'b0 || ia.level !== 4'd0) begin n_fail++; $display("FAIL empty_rw_read: got %h udf=%b lvl=%0d expected 1234 0 0", ia.data_out, ia.underflow, ia.level); end
  endtask

  task automatic test_thresholds();
    logic [8:0] ae_exp;
    logic [8:0] af_exp;
    ae_exp = 9'b000000111;
    af_exp = 9'b111000000;
    for (int l = 0; l <= 8; l++) begin
      #1;
      n_tests++; if (ia.almostempty !== ae_exp[l] || ia.almostfull !== af_exp[l]) begin n_fail++; $display("FAIL thresh_lvl%0d: got ae=%b af=%b expected %b %b", l, ia.almostempty, ia.almostfull, ae_exp[l], af_exp[l]); end
      if (l < 8) begin
        ia.wr_en = 1; ia.data_in = 16'(16'h0100 + l);
        step();
        ia.wr_en = 0;
      end
    end
    ia.af_thresh = 4'd9; ia.ae_thresh = 4'd9;
    #1;
    n_tests++; if (ia.almostfull !== 1'b0 || ia.almostempty !== 1'b1 || ia.full !== 1'b1) begin n_fail++; $display("FAIL thresh_oor: got af=%b ae=%b f=%b expected 0 1 1", ia.almostfull, ia.almostempty, ia.full); end
    ia.af_thresh = 4'd6; ia.ae_thresh = 4'd2;
    ia.flush = 1; ia.wr_en = 1; ia.rd_en = 1;
    step();
    ia.flush = 0; ia.wr_en = 0; ia.rd_en = 0;
    n_tests++; if (ia.level !== 4'd0 || ia.empty !== 1'b1 || ia.wr_ack !== 1'b0 || ia.underflow !== 1'b0) begin n_fail++; $display("FAIL flush_a: got lvl=%0d e=%b ack=%b udf=%b expected 0 1 0 0", ia.level, ia.empty, ia.wr_ack, ia.underflow); end
    n_tests++; if (ia.data_out !== 16'h1234 || ia.rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_a_data: got %h rv=%b expected 1234 0", ia.data_out, ia.rd_valid); end
  endtask

  task automatic test_nonpow2();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        ib.wr_en = 1; ib.data_in = 16'(r * 16 + i + 1);
        step();
      end
      ib.wr_en = 0;
      n_tests++; if (ib.full !== 1'b1 || ib.level !== 3'd6) begin n_fail++; $display("FAIL np2_full_r%0d: got f=%b lvl=%0d expected 1 6", r, ib.full, ib.level); end
      ib.rd_en = 1;
      for (int i = 0; i < 6; i++) begin
        step();
        n_tests++; if (ib.data_out !== 16'(r * 16 + i + 1)) begin n_fail++; $display("FAIL np2_data_r%0d_%0d: got %h expected %h", r, i, ib.data_out, 16'(r * 16 + i + 1)); end
      end
      ib.rd_en = 0;
      n_tests++; if (ib.empty !== 1'b1 || ib.underflow !== 1'b0) begin n_fail++; $display("FAIL np2_empty_r%0d: got e=%b udf=%b expected 1 0", r, ib.empty, ib.underflow); end
    end
  endtask

  task automatic test_fwft();
    ic.wr_en = 1; ic.data_in = 16'h00AA;
    step();
    ic.wr_en = 0;
    n_tests++; if (ic.data_out !== 16'h00AA || ic.rd_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_first: got %h rv=%b expected 00aa 1", ic.data_out, ic.rd_valid); end
    for (int i = 1; i <= 4; i++) begin
      ic.wr_en = 1; ic.data_in = 16'(16'h00B0 + i);
      step();
    end
    ic.wr_en = 0;
    ic.rd_en = 1;
    step();
    ic.rd_en = 0;
    n_tests++; if (ic.data_out !== 16'h00B1 || ic.level !== 4'd4) begin n_fail++; $display("FAIL fwft_pop: got %h lvl=%0d expected 00b1 4", ic.data_out, ic.level); end
    ic.wr_en = 1; ic.data_in = 16'h00B5;
    step();
    ic.wr_en = 0;
    n_tests++; if (ic.level !== 4'd5) begin n_fail++; $display("FAIL fwft_lvl5: got %0d expected 5", ic.level); end
    ic.flush = 1;
    step();
    ic.flush = 0;
    n_tests++; if (ic.level !== 4'd0 || ic.empty !== 1'b1 || ic.rd_valid !== 1'b0 || ic.data_out !== 16'h00B1) begin n_fail++; $display("FAIL fwft_flush: got lvl=%0d e=%b rv=%b do=%h expected 0 1 0 00b1", ic.level, ic.empty, ic.rd_valid, ic.data_out); end
    for (int i = 1; i <= 3; i++) begin
      ic.wr_en = 1; ic.data_in = 16'(16'h00C0 + i);
      step();
    end
    n_tests++; if (ic.wr_ack !== 1'b1 || ic.data_out !== 16'h00C1 || ic.level !== 4'd3) begin n_fail++; $display("FAIL fwft_burst: got ack=%b do=%h lvl=%0d expected 1 00c1 3", ic.wr_ack, ic.data_out, ic.level); end
    #2 rst_n = 0;
    #1;
    n_tests++; if (ic.data_out !== 16'h0 || ic.rd_valid !== 1'b0 || ic.wr_ack !== 1'b0 || ic.level !== 4'd0) begin n_fail++; $display("FAIL midrst_out: got do=%h rv=%b ack=%b lvl=%0d expected 0 0 0 0", ic.data_out, ic.rd_valid, ic.wr_ack, ic.level); end
    n_tests++; if (ic.full !== 1'b0 || ic.empty !== 1'b0 || ic.almostfull !== 1'b0 || ic.almostempty !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got f=%b e=%b af=%b ae=%b expected 0 0 0 0", ic.full, ic.empty, ic.almostfull, ic.almostempty); end
    ic.wr_en = 0;
    step();
    rst_n = 1;
    step();
    n_tests++; if (ic.empty !== 1'b1 || ic.level !== 4'd0 || ic.wr_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_release: got e=%b lvl=%0d ack=%b expected 1 0 0", ic.empty, ic.level, ic.wr_ack); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_rw();
    test_underflow();
    test_thresholds();
    test_nonpow2();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
